// File: rtl/video_scanout.sv
// Display scan-out engine: parametrised H/V timing generator, running word
// address into the framebuffer read port, and a tap pipeline that keeps
// pixel, data enable, syncs and line/frame strobes aligned to the RAM data.
// Stage 0 is the registered counter state; outputs follow RAM_LATENCY+1
// clocks later.
module video_scanout #(
  parameter int   H_ACTIVE      = 1024,
  parameter int   H_FP          = 24,
  parameter int   H_SYNC        = 136,
  parameter int   H_BP          = 160,
  parameter int   V_ACTIVE      = 768,
  parameter int   V_FP          = 3,
  parameter int   V_SYNC        = 6,
  parameter int   V_BP          = 29,
  parameter logic SYNC_POLARITY = 1'b0,
  parameter int   PIXEL_BITS    = 1,
  parameter int   WORD_WIDTH    = 8,
  parameter int   ADDR_WIDTH    = 20,
  parameter int   RAM_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [WORD_WIDTH-1:0] fb_data,
  output logic [PIXEL_BITS-1:0] pixel,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  line_start,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PPW     = WORD_WIDTH / PIXEL_BITS;
  localparam int SEL_W   = (PPW > 1) ? $clog2(PPW) : 1;
  // One spare code so a sync window ending exactly at the line end still fits.
  localparam int H_W     = $clog2(H_TOTAL + 1);
  localparam int V_W     = $clog2(V_TOTAL + 1);

  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_ACT_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [H_W-1:0]   HS_BEG     = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END     = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_ACT_LAST = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0]   VS_BEG     = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END     = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(PPW - 1);

  // Timing flags and pixel-select index carried together down the pipeline.
  typedef struct packed {
    logic             active;
    logic             hsync;
    logic             vsync;
    logic             line;
    logic             frame;
    logic [SEL_W-1:0] sel;
  } tap_t;

  // Stage-0 state. run is low while the scan is parked at the origin, so the
  // first enabled edge only arms the scan and (0,0) is then presented for a
  // full cycle like every other position.
  logic           run;
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;

  tap_t                  s0;
  logic                  word_end;
  logic                  frame_last;
  tap_t                  pipe [RAM_LATENCY];
  tap_t                  tail;
  logic [PIXEL_BITS-1:0] pix_sel;

  // Decode stage-0 counter state into timing flags and address-step conditions.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    s0         = '0;
    word_end   = 1'b0;
    frame_last = 1'b0;
    s0.active  = run && (h < H_ACT) && (v < V_ACT);
    s0.hsync   = run && (h >= HS_BEG) && (h < HS_END);
    s0.vsync   = run && (v >= VS_BEG) && (v < VS_END);
    s0.line    = s0.active && (h == '0);
    s0.frame   = s0.line && (v == '0);
    s0.sel     = (PPW > 1) ? h[SEL_W-1:0] : '0;
    word_end   = s0.active && (s0.sel == SEL_LAST);
    frame_last = (h == H_ACT_LAST) && (v == V_ACT_LAST);
  end

  // Stage-0 raster counters and running word address.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all sequential state so every
    // register samples the pre-edge values of its neighbours.
    if (rst) begin
      run     <= 1'b0;
      h       <= '0;
      v       <= '0;
      fb_addr <= '0;
    end else if (!enable) begin
      run     <= 1'b0;
      h       <= '0;
      v       <= '0;
      fb_addr <= '0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      // Hold the final word through vertical blanking, restart at the origin.
      if ((h == H_LAST) && (v == V_LAST)) begin
        fb_addr <= '0;
      end else if (word_end && !frame_last) begin
        fb_addr <= fb_addr + 1'b1;
      end
    end
  end

  // Delay the stage-0 taps by RAM_LATENCY so they meet the matching read data.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the tap pipeline is a handful of flops, so it is reset like any
    // other register to guarantee idle outputs straight out of reset.
    if (rst) begin
      for (int i = 0; i < RAM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= s0;
      for (int i = 1; i < RAM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Select the addressed pixel from the returned word, pixel 0 in the LSBs.
  always_comb begin
    tail    = pipe[RAM_LATENCY-1];
    pix_sel = PIXEL_BITS'(fb_data >> (int'(tail.sel) * PIXEL_BITS));
  end

  // Output register: all display-facing signals leave from flops together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de          <= 1'b0;
      hsync       <= ~SYNC_POLARITY;
      vsync       <= ~SYNC_POLARITY;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pixel       <= '0;
    end else begin
      de          <= tail.active;
      hsync       <= tail.hsync ? SYNC_POLARITY : ~SYNC_POLARITY;
      vsync       <= tail.vsync ? SYNC_POLARITY : ~SYNC_POLARITY;
      line_start  <= tail.line;
      frame_start <= tail.frame;
      pixel       <= tail.active ? pix_sel : '0;
    end
  end

endmodule
